// File: rtl/rf_wr_arbiter_if.sv
// Bundle of the writeback requester handshakes, the register-file write port
// and the forwarded read paths seen by rf_wr_arbiter.
interface rf_wr_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  rf_wr_en;
    logic [ADDR_WIDTH-1:0] rf_wr_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;

    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic [DATA_WIDTH-1:0] rf_rd_data1;
    logic [DATA_WIDTH-1:0] rf_rd_data2;
    logic [DATA_WIDTH-1:0] fwd_data1;
    logic [DATA_WIDTH-1:0] fwd_data2;

    logic [15:0]           conflict_cnt;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
        output fwd_data1, fwd_data2,
        output conflict_cnt
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_wr_en, rf_wr_addr, rf_wr_data,
        output rd_addr1, rd_addr2, rf_rd_data1, rf_rd_data2,
        input  fwd_data1, fwd_data2,
        input  conflict_cnt
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU and load-unit writeback paths, with write-to-read forwarding.
module rf_wr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    rf_wr_arbiter_if.slave  bus
);

    logic                  grant0_s;
    logic                  grant1_s;

    logic                  last_q;
    logic                  last_d;
    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [15:0]           conflict_q;
    logic [15:0]           conflict_d;

    // Grant selection; last_q=1 means req1 won most recently, so req0 wins a tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            if (last_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (bus.req0_valid) begin
            grant0_s = 1'b1;
        end else if (bus.req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next-state for the write stage, priority bit and conflict counter.
    always_comb begin
        last_d     = last_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        conflict_d = conflict_q;
        if (grant0_s) begin
            last_d    = 1'b0;
            wr_en_d   = 1'b1;
            wr_addr_d = bus.req0_addr;
            wr_data_d = bus.req0_data;
        end else if (grant1_s) begin
            last_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = bus.req1_addr;
            wr_data_d = bus.req1_data;
        end else begin
            last_d  = last_q;
            wr_en_d = 1'b0;
        end
        if (bus.req0_valid && bus.req1_valid && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State registers; reset also drops any write not yet committed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_data_q  <= {DATA_WIDTH{1'b0}};
            conflict_q <= 16'd0;
        end else begin
            last_q     <= last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            conflict_q <= conflict_d;
        end
    end

    // Forward the in-flight write; register 0 is an ordinary register here.
    always_comb begin
        if (wr_en_q && (wr_addr_q == bus.rd_addr1)) begin
            bus.fwd_data1 = wr_data_q;
        end else begin
            bus.fwd_data1 = bus.rf_rd_data1;
        end
        if (wr_en_q && (wr_addr_q == bus.rd_addr2)) begin
            bus.fwd_data2 = wr_data_q;
        end else begin
            bus.fwd_data2 = bus.rf_rd_data2;
        end
    end

    assign bus.req0_ready   = grant0_s;
    assign bus.req1_ready   = grant1_s;
    assign bus.rf_wr_en     = wr_en_q;
    assign bus.rf_wr_addr   = wr_addr_q;
    assign bus.rf_wr_data   = wr_data_q;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with a behavioural register file behind it.
module tb_rf_wr_arbiter;

    logic clk;
    logic rst_n;
    logic preload;
    int   total;
    int   bad;

    logic [31:0] mem [32];

    rf_wr_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    rf_wr_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: preloaded with 0xDEAD00nn, held in reset with the arbiter.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 32'hDEAD0000 | i;
            end
        end else if (bus.rf_wr_en && rst_n) begin
            mem[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
    end

    assign bus.rf_rd_data1 = mem[bus.rd_addr1];
    assign bus.rf_rd_data2 = mem[bus.rd_addr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        preload = 1'b1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'h12345678;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h33333333;
        bus.rd_addr1 = 5'd0;   bus.rd_addr2 = 5'd0;

        // Reset held for two edges with both valids high
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            preload = 1'b0;
            chk("rst_ready0", bus.req0_ready, 32'd0);
            chk("rst_ready1", bus.req1_ready, 32'd0);
            chk("rst_wr_en", bus.rf_wr_en, 32'd0);
            chk("rst_conflict", bus.conflict_cnt, 32'd0);
            chk("rst_wr_addr", bus.rf_wr_addr, 32'd0);
            chk("rst_fwd1", bus.fwd_data1, 32'hDEAD0000);
        end

        // Release: req0 wins the first conflict, writes addr 0
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", bus.req0_ready, 32'd1);
        chk("rel_ready1", bus.req1_ready, 32'd0);

        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("w0_ready1", bus.req1_ready, 32'd1);
        chk("w0_wr_en", bus.rf_wr_en, 32'd1);
        chk("w0_wr_addr", bus.rf_wr_addr, 32'd0);
        chk("w0_wr_data", bus.rf_wr_data, 32'h12345678);
        chk("w0_fwd_r0", bus.fwd_data1, 32'h12345678);
        chk("w0_conflict", bus.conflict_cnt, 32'd1);

        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        chk("w1_wr_addr", bus.rf_wr_addr, 32'd3);
        chk("w1_rd_r0", bus.fwd_data1, 32'h12345678);
        chk("w1_ready0", bus.req0_ready, 32'd0);

        @(negedge clk); #1;
        chk("idle_wr_en", bus.rf_wr_en, 32'd0);
        chk("idle_wr_data", bus.rf_wr_data, 32'h33333333);
        rst_n = 1'b0;

        // Fresh reset, then four cycles of continuous conflict
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd2; bus.req0_data = 32'h22222222;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h33333333;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("alt_ready0", bus.req0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_ready1", bus.req1_ready, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("alt_conflict", bus.conflict_cnt, i);
            if (i > 0) begin
                chk("alt_wr_en", bus.rf_wr_en, 32'd1);
                chk("alt_wr_addr", bus.rf_wr_addr, (i % 2 == 1) ? 32'd2 : 32'd3);
            end else begin
                chk("alt_wr_en0", bus.rf_wr_en, 32'd0);
            end
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("alt_last_addr", bus.rf_wr_addr, 32'd3);
        chk("alt_conflict4", bus.conflict_cnt, 32'd4);

        // Forwarding on port 1 only
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd1; bus.req1_data = 32'hAABBCCDD;
        bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd0;
        #1;
        chk("fwd_ready1", bus.req1_ready, 32'd1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        chk("fwd_n1_p1", bus.fwd_data1, 32'hAABBCCDD);
        chk("fwd_n1_p2", bus.fwd_data2, 32'h12345678);
        @(negedge clk); #1;
        chk("fwd_n2_p1", bus.fwd_data1, 32'hAABBCCDD);
        chk("fwd_n2_p2", bus.fwd_data2, 32'h12345678);
        chk("fwd_n2_wr_en", bus.rf_wr_en, 32'd0);

        // Same destination from both requesters
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h00000001;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd5; bus.req1_data = 32'h00000002;
        bus.rd_addr1 = 5'd5;
        #1;
        chk("same_ready0", bus.req0_ready, 32'd1);
        chk("same_old", bus.fwd_data1, 32'hDEAD0005);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("same_ready1", bus.req1_ready, 32'd1);
        chk("same_first", bus.fwd_data1, 32'h00000001);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        chk("same_second", bus.fwd_data1, 32'h00000002);
        @(negedge clk); #1;
        chk("same_final", bus.fwd_data1, 32'h00000002);
        chk("same_conflict", bus.conflict_cnt, 32'd5);

        // Reset lands while a write to addr 7 is still pending
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77777777;
        bus.rd_addr1 = 5'd7;
        #1;
        chk("mid_ready0", bus.req0_ready, 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99999999;
        rst_n = 1'b0;
        #1;
        chk("mid_pending", bus.rf_wr_en, 32'd1);
        chk("mid_ready1_rst", bus.req1_ready, 32'd0);
        @(negedge clk); #1;
        chk("mid_wr_en", bus.rf_wr_en, 32'd0);
        chk("mid_wr_addr", bus.rf_wr_addr, 32'd0);
        chk("mid_wr_data", bus.rf_wr_data, 32'd0);
        chk("mid_conflict", bus.conflict_cnt, 32'd0);
        chk("mid_addr7", bus.fwd_data1, 32'hDEAD0007);
        rst_n = 1'b1;
        bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("mid_addr7_after", bus.fwd_data1, 32'hDEAD0007);
        chk("mid_idle", bus.rf_wr_en, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port arbiter for the 2-read/1-write register file (`reg_file`, ADDR_WIDTH=5, DATA_WIDTH=32). It shares the single RF write port between two writeback requesters using a valid/ready handshake with round-robin priority, and registers the winning write into the RF port. It also forwards the in-flight write onto both read paths, so consumers never see stale data during the write cycle. It sits between the writeback sources (req0 = ALU, req1 = load unit) and `reg_file`.

## Interface
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_WIDTH  requester 0 destination register
- req0_data  in  DATA_WIDTH  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for requester 1
- rf_wr_en  out  1  to `reg_file` wr_en
- rf_wr_addr  out  ADDR_WIDTH  to `reg_file` wr_addr
- rf_wr_data  out  DATA_WIDTH  to `reg_file` wr_data
- rd_addr1, rd_addr2  in  ADDR_WIDTH  read addresses, also driven to `reg_file`
- rf_rd_data1, rf_rd_data2  in  DATA_WIDTH  raw `reg_file` read data
- fwd_data1, fwd_data2  out  DATA_WIDTH  forwarded read data
- conflict_cnt  out  16  count of cycles in which both requesters were valid

## Operation
- Handshake: a transfer occurs in a cycle when reqN_valid=1 and reqN_ready=1. Requesters hold valid/addr/data stable until ready.
- reqN_ready is combinational from the valids and the priority state. It is never asserted for both requesters in the same cycle, and is forced to 0 while rst_n=0.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - Neither valid: no grant, priority state unchanged.
- Priority state `last` (1 bit) updates to the granted index on each transfer. After reset `last`=1, so req0 wins the first conflict.
- Write stage: on a transfer, the next edge loads rf_wr_en=1 and rf_wr_addr/rf_wr_data from the winner. With no transfer, rf_wr_en=0 and addr/data hold their values.
- Forwarding: fwd_dataK = rf_wr_data when rf_wr_en=1 and rf_wr_addr==rd_addrK; otherwise fwd_dataK = rf_rd_dataK. This is combinational and independent per port. Register 0 is forwarded like any other register, because the RF has no hardwired zero.
- conflict_cnt increments on each cycle with req0_valid & req1_valid and saturates at 16'hFFFF.
- Same destination from both requesters in back-to-back grants: writes reach the RF in grant order, so the later grant's data is final.

## Timing
- Reset (rst_n=0 at an edge): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, last=1, conflict_cnt=0. fwd_dataK follows rf_rd_dataK.
- Reset mid-operation: a write registered but not yet committed is dropped, because rf_wr_en clears at the reset edge. Transfers presented during the reset cycle are not accepted.
- Latency: a transfer in cycle N puts rf_wr_en=1 in cycle N+1, and the RF commits at the end of N+1. The RF read returns the new value from cycle N+2; forwarding covers cycle N+1.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1,…
- A requester losing arbitration waits at most one cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both valids high -> both readies 0, rf_wr_en=0, conflict_cnt=0. Release -> req0 granted first.
- Single write: req0 writes addr 0 = 32'h12345678 -> req0_ready=1 in cycle N; rf_wr_en=1, rf_wr_addr=0 in N+1; rd_addr1=0 returns 12345678 at N+2.
- Conflict alternation: both valid for 4 cycles (req0 addr 2, req1 addr 3, distinct data) -> grant order 0,1,0,1; conflict_cnt=4; rf_wr_addr sequence 2,3,2,3.
- Forwarding: req1 writes addr 1 = 32'hAABBCCDD with rd_addr1=1 and rd_addr2=0 -> in N+1 fwd_data1=AABBCCDD while fwd_data2 equals rf_rd_data2; in N+2 both ports show RF data.
- Same-address ordering: req0 writes addr 5 = 32'h1, req1 writes addr 5 = 32'h2, both valid -> req0 commits first, req1 second; the final read of addr 5 returns 32'h2.
- Reset mid-write: assert rst_n=0 in cycle N+1 after a transfer to addr 7 -> rf_wr_en=0 after that edge, and addr 7 keeps its previous value.
